// File: rtl/sext_unit_if.sv
// Handshake and data bundle for sext_unit: producer-side (master) and unit-side (slave) views.
// The shamt field only exists when SEXT_SHIFT_EN is defined.
interface sext_unit_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  in_data;
    logic             in_signed;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] comb_out;
`ifdef SEXT_SHIFT_EN
    logic [$clog2(OUT_W)-1:0] shamt;
`endif

    modport master (
        output in_data, in_signed, in_valid, out_ready,
`ifdef SEXT_SHIFT_EN
        output shamt,
`endif
        input  in_ready, out_data, out_valid, comb_out
    );

    modport slave (
        input  in_data, in_signed, in_valid, out_ready,
`ifdef SEXT_SHIFT_EN
        input  shamt,
`endif
        output in_ready, out_data, out_valid, comb_out
    );
endinterface

// File: rtl/sext_unit.sv
// Sign/zero extension unit: combinational sign-extend path plus a one-deep registered
// valid/ready path. Defining SEXT_SHIFT_EN adds a left shift (shamt) on the registered result.
module sext_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input logic      clk,
    input logic      rst_n,
    sext_unit_if.slave bus
);
    localparam int SH_W = $clog2(OUT_W);

    logic [SH_W-1:0]  shamt;
    logic [OUT_W-1:0] ext_signed;
    logic [OUT_W-1:0] ext_unsigned;
    logic [OUT_W-1:0] ext_result;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic [OUT_W-1:0] out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;

`ifdef SEXT_SHIFT_EN
    assign shamt = bus.shamt;
`else
    assign shamt = '0;
`endif

    // Size casts extend by the operand's signedness and stay legal when IN_W == OUT_W.
    always_comb begin
        ext_signed   = OUT_W'($signed(bus.in_data));
        ext_unsigned = OUT_W'(bus.in_data);
        ext_result   = (bus.in_signed ? ext_signed : ext_unsigned) << shamt;
    end

    assign bus.comb_out = ext_signed;

    always_comb begin
        in_ready    = !out_valid_q || bus.out_ready;
        accept      = bus.in_valid && in_ready;
        consume     = out_valid_q && bus.out_ready;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = ext_result;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sext_unit.sv
// Self-checking bench for sext_unit: a negedge monitor keeps a scoreboard of expected
// registered results; directed checks cover reset, comb path, backpressure and streaming.
module tb_sext_unit;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int SH_W  = $clog2(OUT_W);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [SH_W-1:0] shamt_v = '0;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    sext_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sext_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

`ifdef SEXT_SHIFT_EN
    assign bus.shamt = shamt_v;
`endif

    function automatic logic [31:0] model(input logic [15:0] d, input logic s,
                                          input logic [SH_W-1:0] sh);
        logic [31:0] e;
        e = s ? {{16{d[15]}}, d} : {16'h0000, d};
        return e << sh;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One cycle with the given inputs; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [15:0] d, input logic s,
                                 input logic v, input logic r);
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_valid  = v;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Inputs settle long before the falling edge, so what is seen here is what the next edge uses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput("sb_data", bus.out_data, sb[0]);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        popped++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_data, bus.in_signed, shamt_v));
        end
    end

    logic [15:0] vec_in  [8] = '{16'h0035, 16'h0020, 16'hFFED, 16'hFFD9,
                                 16'hF1E1, 16'h256C, 16'hDBE3, 16'h8000};
    logic [31:0] comb_exp[7] = '{32'h00000035, 32'h00000020, 32'hFFFFFFED, 32'hFFFFFFD9,
                                 32'hFFFFF1E1, 32'h0000256C, 32'hFFFFDBE3};

    initial begin
        int p0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data", bus.out_data, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus.in_data = vec_in[i];
            #1;
            checkOutput("comb", bus.comb_out, comb_exp[i]);
        end
        @(posedge clk);
        #1;

        applyStimulus(16'hDBE3, 1'b1, 1'b1, 1'b1);
        checkOutput("reg_signed_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("reg_signed_data", bus.out_data, 32'hFFFFDBE3);
        applyStimulus(16'hFFED, 1'b0, 1'b1, 1'b1);
        checkOutput("reg_zero_data", bus.out_data, 32'h0000FFED);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drain_hold", bus.out_data, 32'h0000FFED);

        applyStimulus(16'h0035, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.in_data = 16'h0020; bus.in_signed = 1'b1;
        #1;
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0020, 1'b1, 1'b1, 1'b0);
            checkOutput("bp_hold_data", bus.out_data, 32'h00000035);
            checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp_swap_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("bp_swap_data", bus.out_data, 32'h00000020);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);

        p0 = popped;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vec_in[i], (i % 3) != 1, 1'b1, 1'b1);
            checkOutput("stream_valid", 32'(bus.out_valid), 32'd1);
        end
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("stream_count", 32'(popped - p0), 32'd8);

        applyStimulus(16'h1234, 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_rst_data", bus.out_data, 32'd0);
        checkOutput("async_rst_comb", bus.comb_out, 32'h00001234);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);
        checkOutput("post_rst_data", bus.out_data, 32'hFFFFFFFF);

`ifdef SEXT_SHIFT_EN
        shamt_v = SH_W'(1);
        applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);
        checkOutput("shift1", bus.out_data, 32'hFFFFFFFE);
        shamt_v = SH_W'(31);
        applyStimulus(16'h0001, 1'b0, 1'b1, 1'b1);
        checkOutput("shift31", bus.out_data, 32'h80000000);
        bus.in_data = 16'hFFFF;
        #1;
        checkOutput("shift_comb_unshifted", bus.comb_out, 32'hFFFFFFFF);
        shamt_v = '0;
`endif
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
